// File: rtl/aes_delay_model_pkg.sv
// Shared constants, entry type and latency helpers for the multi-channel AES latency model.
package aes_delay_model_pkg;

    localparam int unsigned STAT_W        = 32;
    localparam int unsigned DDRDWidth     = 512;
    localparam int unsigned DefMaxLatency = 63;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned DefLatW = clog2(DefMaxLatency + 1);

    // Reference layout of one buffered beat at the default widths.
    typedef struct packed {
        logic [DDRDWidth-1:0] data;
        logic [DefLatW-1:0]   cnt;
    } entry_t;

    function automatic int unsigned clampLat(input int unsigned lat, input int unsigned maxLat);
        return (lat > maxLat) ? maxLat : lat;
    endfunction

    // Counter start value: L=0 and L=1 both present the beat one cycle after acceptance.
    function automatic int unsigned initCnt(input int unsigned lat, input int unsigned maxLat);
        int unsigned c;
        c = clampLat(lat, maxLat);
        return (c == 0) ? 0 : c - 1;
    endfunction

endpackage

// File: rtl/aes_delay_model_if.sv
// Flattened per-channel streams of aes_delay_model_mc.
// StatStall exists only when AES_DELAY_STATS_EN is defined.
interface aes_delay_model_if #(
    parameter int unsigned Width    = 512,
    parameter int unsigned Channels = 2,
    parameter int unsigned LatW     = 6
);
    import aes_delay_model_pkg::*;

    logic [Channels*LatW-1:0]  Latency;
    logic [Channels*Width-1:0] DataIn;
    logic [Channels-1:0]       DataInValid;
    logic [Channels-1:0]       DataInReady;
    logic [Channels*Width-1:0] DataOut;
    logic [Channels-1:0]       DataOutValid;
    logic [Channels-1:0]       DataOutReady;

`ifdef AES_DELAY_STATS_EN
    logic [Channels*STAT_W-1:0] StatStall;

    modport master (
        output Latency, DataIn, DataInValid, DataOutReady,
        input  DataInReady, DataOut, DataOutValid, StatStall
    );
    modport slave (
        input  Latency, DataIn, DataInValid, DataOutReady,
        output DataInReady, DataOut, DataOutValid, StatStall
    );
`else
    modport master (
        output Latency, DataIn, DataInValid, DataOutReady,
        input  DataInReady, DataOut, DataOutValid
    );
    modport slave (
        input  Latency, DataIn, DataInValid, DataOutReady,
        output DataInReady, DataOut, DataOutValid
    );
`endif

endinterface

// File: rtl/aes_delay_model_chan.sv
// One latency-model channel: circular buffer of {data, cnt}, in-order release when head cnt hits 0.
// Optional stall counter under AES_DELAY_STATS_EN.
module aes_delay_model_chan
    import aes_delay_model_pkg::*;
#(
    parameter int unsigned Width      = 512,
    parameter int unsigned Depth      = 32,
    parameter int unsigned MaxLatency = 63,
    parameter int unsigned LatW       = clog2(MaxLatency + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [LatW-1:0]  Latency,
    input  logic [Width-1:0] DataIn,
    input  logic             DataInValid,
    output logic             DataInReady,
    output logic [Width-1:0] DataOut,
    output logic             DataOutValid,
    input  logic             DataOutReady
`ifdef AES_DELAY_STATS_EN
    ,
    output logic [STAT_W-1:0] StatStall
`endif
);
    localparam int unsigned PtrW = clog2(Depth);
    localparam int unsigned OccW = clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [OccW-1:0] DepthOcc = OccW'(Depth);

    typedef struct packed {
        logic [Width-1:0] data;
        logic [LatW-1:0]  cnt;
    } entryT;

    entryT            mem [Depth];
    logic [PtrW-1:0]  wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
    logic [OccW-1:0]  occQ, occD;
    logic [Width-1:0] holdQ;
    logic [LatW-1:0]  newCnt;
    logic             push, pop;

    // Ready depends only on registered occupancy, never on DataOutReady.
    assign DataInReady  = occQ < DepthOcc;
    assign push         = DataInValid && DataInReady;
    assign DataOutValid = (occQ != '0) && (mem[rdPtrQ].cnt == '0);
    assign pop          = DataOutValid && DataOutReady;
    assign DataOut      = DataOutValid ? mem[rdPtrQ].data : holdQ;
    assign newCnt       = LatW'(initCnt(32'(Latency), MaxLatency));

    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        occD   = occQ;
        if (push) begin
            wrPtrD = (wrPtrQ == LastPtr) ? '0 : wrPtrQ + PtrW'(1);
        end
        if (pop) begin
            rdPtrD = (rdPtrQ == LastPtr) ? '0 : rdPtrQ + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   occD = occQ + OccW'(1);
            2'b01:   occD = occQ - OccW'(1);
            default: occD = occQ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            occQ   <= '0;
            holdQ  <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            occQ   <= occD;
            holdQ  <= DataOut;
        end
    end

    // Stored counters tick down every edge; a freshly written slot overrides its own tick.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[PtrW'(i)].cnt <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (mem[PtrW'(i)].cnt != '0) begin
                    mem[PtrW'(i)].cnt <= mem[PtrW'(i)].cnt - LatW'(1);
                end
            end
            if (push) begin
                mem[wrPtrQ] <= '{data: DataIn, cnt: newCnt};
            end
        end
    end

`ifdef AES_DELAY_STATS_EN
    logic [STAT_W-1:0] statQ;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            statQ <= '0;
        end else if (DataInValid && !DataInReady && (statQ != '1)) begin
            statQ <= statQ + STAT_W'(1);
        end
    end

    assign StatStall = statQ;
`endif

endmodule

// File: rtl/aes_delay_model_mc.sv
// Multi-channel AES latency model: one independent delay channel per lane.
// Build with AES_DELAY_STATS_EN to add per-channel StatStall counters.
module aes_delay_model_mc
    import aes_delay_model_pkg::*;
#(
    parameter int unsigned Width      = DDRDWidth,
    parameter int unsigned Channels   = 2,
    parameter int unsigned Depth      = 32,
    parameter int unsigned MaxLatency = DefMaxLatency,
    parameter int unsigned LatW       = clog2(MaxLatency + 1)
) (
    input logic             Clock,
    input logic             Reset,
    aes_delay_model_if.slave bus
);

    for (genvar c = 0; c < Channels; c++) begin : gChan
        aes_delay_model_chan #(
            .Width      (Width),
            .Depth      (Depth),
            .MaxLatency (MaxLatency),
            .LatW       (LatW)
        ) uChan (
            .Clock        (Clock),
            .Reset        (Reset),
            .Latency      (bus.Latency[c*LatW +: LatW]),
            .DataIn       (bus.DataIn[c*Width +: Width]),
            .DataInValid  (bus.DataInValid[c]),
            .DataInReady  (bus.DataInReady[c]),
            .DataOut      (bus.DataOut[c*Width +: Width]),
            .DataOutValid (bus.DataOutValid[c]),
            .DataOutReady (bus.DataOutReady[c])
`ifdef AES_DELAY_STATS_EN
            ,
            .StatStall    (bus.StatStall[c*STAT_W +: STAT_W])
`endif
        );
    end

endmodule

// File: tb/tb_aes_delay_model_mc.sv
// Directed bench for aes_delay_model_mc; adds a stall-counter test when AES_DELAY_STATS_EN is defined.
module tb_aes_delay_model_mc;
    localparam int unsigned W  = 512;
    localparam int unsigned LW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    aes_delay_model_if #(.Width(W), .Channels(2), .LatW(LW)) bus ();

    aes_delay_model_mc #(
        .Width      (W),
        .Channels   (2),
        .Depth      (32),
        .MaxLatency (63),
        .LatW       (LW)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic checkEq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input int c, input logic vld, input logic [W-1:0] d, input int lat);
        bus.DataInValid[c]       = vld;
        bus.DataIn[c*W +: W]     = d;
        bus.Latency[c*LW +: LW]  = LW'(lat);
    endtask

    function automatic logic [W-1:0] outData(input int c);
        return bus.DataOut[c*W +: W];
    endfunction

    int firstK, secondK, nValid, nValid1, acc, firstBlock, bad, n, stalls;
    logic [W-1:0] d1, d2;

    initial begin
        bus.Latency      = '0;
        bus.DataIn       = '0;
        bus.DataInValid  = '0;
        bus.DataOutReady = 2'b11;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkEq("rst valid", W'(bus.DataOutValid), 0);
        checkEq("rst ready", W'(bus.DataInReady), 3);
        checkEq("rst dout0", outData(0), 0);
        checkEq("rst dout1", outData(1), 0);

        // Single beat, L=5
        @(posedge clk); #1;
        setIn(0, 1'b1, W'('hA5), 5);
        tick();
        bus.DataInValid[0] = 1'b0;
        firstK = 0; nValid = 0; nValid1 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.DataOutValid[1]) nValid1++;
            if (bus.DataOutValid[0]) begin
                nValid++;
                if (firstK == 0) begin
                    firstK = k;
                    d1 = outData(0);
                end
            end
        end
        checkEq("L5 first cycle", W'(firstK), 5);
        checkEq("L5 valid count", W'(nValid), 1);
        checkEq("L5 data", d1, W'('hA5));
        checkEq("L5 ch1 idle", W'(nValid1), 0);

        // Streaming at L=0 and L=1
        for (int lat = 0; lat <= 1; lat++) begin
            bad = 0;
            @(posedge clk); #1;
            for (int i = 0; i <= 100; i++) begin
                if (i < 100) setIn(0, 1'b1, W'(32'h1000 * (lat + 1) + i), lat);
                else         bus.DataInValid[0] = 1'b0;
                @(negedge clk);
                if (bus.DataOutValid[0] !== (i > 0)) bad++;
                if (i > 0 && outData(0) !== W'(32'h1000 * (lat + 1) + i - 1)) bad++;
                if (bus.DataInReady[0] !== 1'b1) bad++;
                tick();
            end
            checkEq(lat == 0 ? "stream L0 errs" : "stream L1 errs", W'(bad), 0);
        end

        // Fill to full with output blocked, L=3
        bus.DataOutReady[0] = 1'b0;
        acc = 0; firstBlock = -1;
        for (int i = 0; i < 40; i++) begin
            setIn(0, 1'b1, W'(32'h300 + i), 3);
            @(negedge clk);
            if (bus.DataInReady[0]) acc++;
            else if (firstBlock < 0) firstBlock = i;
            tick();
        end
        bus.DataInValid[0] = 1'b0;
        checkEq("full accepted", W'(acc), 32);
        checkEq("full ready drop", W'(firstBlock), 32);
        @(negedge clk);
        checkEq("full head valid", W'(bus.DataOutValid[0]), 1);
        checkEq("full head data", outData(0), W'(32'h300));
        checkEq("full ch1 ready", W'(bus.DataInReady[1]), 1);
        @(posedge clk); #1;
        bus.DataOutReady[0] = 1'b1;
        n = 0; bad = 0;
        for (int cyc = 0; cyc < 60 && n < 32; cyc++) begin
            @(negedge clk);
            if (n == 0 && bus.DataInReady[0] !== 1'b0) bad++;
            if (bus.DataOutValid[0]) begin
                if (outData(0) !== W'(32'h300 + n)) bad++;
                n++;
            end
            tick();
        end
        checkEq("drain count", W'(n), 32);
        checkEq("drain order", W'(bad), 0);
        @(negedge clk);
        checkEq("drain ready back", W'(bus.DataInReady[0]), 1);
        checkEq("drain empty", W'(bus.DataOutValid[0]), 0);

        // Long beat then short beat: order kept
        @(posedge clk); #1;
        setIn(0, 1'b1, W'('hAAAA), 10);
        tick();
        setIn(0, 1'b1, W'('hBBBB), 1);
        tick();
        bus.DataInValid[0] = 1'b0;
        firstK = 0; secondK = 0; nValid = 0;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            if (bus.DataOutValid[0]) begin
                nValid++;
                if (firstK == 0) begin
                    firstK = k; d1 = outData(0);
                end else if (secondK == 0) begin
                    secondK = k; d2 = outData(0);
                end
            end
        end
        checkEq("hol A cycle", W'(firstK), 10);
        checkEq("hol A data", d1, W'('hAAAA));
        checkEq("hol B cycle", W'(secondK), 11);
        checkEq("hol B data", d2, W'('hBBBB));
        checkEq("hol count", W'(nValid), 2);

        // Reset with 7 beats buffered on both channels
        @(posedge clk); #1;
        bus.DataOutReady = 2'b00;
        for (int i = 0; i < 7; i++) begin
            setIn(0, 1'b1, W'(32'h700 + i), 3);
            setIn(1, 1'b1, W'(32'h800 + i), 3);
            tick();
        end
        bus.DataInValid = 2'b00;
        tick();
        @(negedge clk);
        checkEq("pre-rst valid", W'(bus.DataOutValid), 3);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkEq("mid rst valid", W'(bus.DataOutValid), 0);
        checkEq("mid rst ready", W'(bus.DataInReady), 3);
        checkEq("mid rst dout0", outData(0), 0);
        @(posedge clk); #1;
        bus.DataOutReady = 2'b11;
        setIn(0, 1'b1, W'('hC0C0), 2);
        tick();
        bus.DataInValid[0] = 1'b0;
        firstK = 0; nValid = 0; nValid1 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.DataOutValid[1]) nValid1++;
            if (bus.DataOutValid[0]) begin
                nValid++;
                if (firstK == 0) begin
                    firstK = k; d1 = outData(0);
                end
            end
        end
        checkEq("post rst cycle", W'(firstK), 2);
        checkEq("post rst data", d1, W'('hC0C0));
        checkEq("post rst ch0 count", W'(nValid), 1);
        checkEq("post rst ch1 stale", W'(nValid1), 0);

`ifdef AES_DELAY_STATS_EN
        // Stall counter: 50 cycles held past full on channel 1
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.DataOutReady = 2'b00;
        setIn(1, 1'b1, W'('h51), 1);
        stalls = 0;
        for (int cyc = 0; cyc < 200 && stalls < 50; cyc++) begin
            @(negedge clk);
            if (!bus.DataInReady[1]) stalls++;
            if (stalls < 50) tick();
        end
        @(posedge clk); #1;
        bus.DataInValid[1] = 1'b0;
        @(negedge clk);
        checkEq("stat ch1", W'(bus.StatStall[32 +: 32]), 50);
        checkEq("stat ch0", W'(bus.StatStall[0 +: 32]), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
